// File: rtl/des_round_engine.sv
// DES Feistel round engine: runs the 16 rounds on a post-IP block, UNROLL rounds per clock,
// with a valid/ready handshake on both sides and a tag carried alongside each block.
`timescale 1ns/1ps

module des_round_engine #(
  parameter int UNROLL = 1,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [767:0]     in_keys,
  input  logic             in_decrypt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  genvar gi;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("des_round_engine: UNROLL must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]       state_q, state_d;
  logic [4:0]       rc_q, rc_d;
  logic [63:0]      blk_q, blk_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             dec_q, dec_d;
  logic [767:0]     keys_q;
  logic             accept_w, last_w;
  logic [63:0]      chain_w [UNROLL+1];
  logic [47:0]      key_arr [16];

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept_w  = in_valid & in_ready;
  assign last_w    = (rc_q == 5'(16 - UNROLL));
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign out_data  = {blk_q[31:0], blk_q[63:32]};
  assign out_tag   = tag_q;

  for (gi = 0; gi < 16; gi++) begin : g_key
    assign key_arr[gi] = keys_q[767-48*gi -: 48];
  end

  // Rounds rc .. rc+UNROLL-1 evaluated combinationally from the state register.
  assign chain_w[0] = blk_q;
  for (gi = 0; gi < UNROLL; gi++) begin : g_round
    logic [3:0] rnd;
    logic [3:0] kidx;
    assign rnd  = rc_q[3:0] + 4'(gi);
    assign kidx = dec_q ? (4'd15 - rnd) : rnd;
    round u_round (
      .data_i (chain_w[gi]),
      .key_i  (key_arr[kidx]),
      .data_o (chain_w[gi+1])
    );
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    blk_d   = blk_q;
    tag_d   = tag_q;
    dec_d   = dec_q;
    if (accept_w) begin
      state_d = S_RUN;
      rc_d    = '0;
      blk_d   = in_data;
      tag_d   = in_tag;
      dec_d   = in_decrypt;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_RUN: begin
          blk_d = chain_w[UNROLL];
          rc_d  = rc_q + 5'(UNROLL);
          if (last_w) state_d = S_DONE;
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rc_q    <= '0;
      blk_q   <= '0;
      tag_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      blk_q   <= blk_d;
      tag_q   <= tag_d;
      dec_q   <= dec_d;
    end
  end

  // Key register needs no reset: it is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (accept_w) keys_q <= in_keys;
  end
endmodule

// Single DES round: {L, R} -> {R, L ^ f(R, K)}.
module round (
  input  logic [63:0] data_i,
  input  logic [47:0] key_i,
  output logic [63:0] data_o
);
  localparam int E_TAB [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                                12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
                                24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  // Each S-box packed row-major, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  genvar gi;

  logic [31:0] r_w, s_w, p_w;
  logic [47:0] e_w, x_w;

  assign r_w = data_i[31:0];
  for (gi = 0; gi < 48; gi++) begin : g_e
    assign e_w[47-gi] = r_w[32-E_TAB[gi]];
  end
  assign x_w = e_w ^ key_i;

  // Row = outer bits, column = inner four; nibble of entry n sits at bit 4*(63-n)+3.
  for (gi = 0; gi < 8; gi++) begin : g_sbox
    logic [5:0] idx;
    logic [7:0] sel;
    assign idx = {x_w[47-6*gi], x_w[42-6*gi], x_w[46-6*gi -: 4]};
    assign sel = {~idx, 2'b11};
    assign s_w[31-4*gi -: 4] = SBOX[gi][sel -: 4];
  end

  for (gi = 0; gi < 32; gi++) begin : g_p
    assign p_w[31-gi] = s_w[32-P_TAB[gi]];
  end

  assign data_o = {r_w, data_i[63:32] ^ p_w};
endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: all five UNROLL variants run side by side on shared stimulus,
// checked against a table-driven DES model (key schedule, IP/FP, rounds) kept here.
`timescale 1ns/1ps

module tb_des_round_engine;
  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                              12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
                              24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [63:0]  in_data;
  logic [767:0] in_keys;
  logic         in_decrypt;
  logic [7:0]   in_tag;
  logic         out_ready;
  logic         in_ready_w  [5];
  logic         out_valid_w [5];
  logic         busy_w      [5];
  logic [63:0]  out_data_w  [5];
  logic [7:0]   out_tag_w   [5];

  int checks = 0;
  int errors = 0;
  int blk_no = 0;
  logic [63:0] last_out [5];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    des_round_engine #(.UNROLL(1 << gi), .TAG_W(8)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready_w[gi]),
      .in_data    (in_data),
      .in_keys    (in_keys),
      .in_decrypt (in_decrypt),
      .in_tag     (in_tag),
      .out_valid  (out_valid_w[gi]),
      .out_ready  (out_ready),
      .out_data   (out_data_w[gi]),
      .out_tag    (out_tag_w[gi]),
      .busy       (busy_w[gi])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] do_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] do_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[64-IP_T[i]] = x[63-i];
    return y;
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0]  x;
    logic [31:0]  s;
    logic [31:0]  y;
    logic [5:0]   six;
    logic [255:0] tmp;
    int row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int si = 0; si < 8; si++) begin
      six = x[47-6*si -: 6];
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      tmp = SB[si] >> (4 * (63 - (row * 16 + col)));
      s[31-4*si -: 4] = tmp[3:0];
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] blk, input logic [767:0] keys, input logic dec);
    logic [31:0] l, r, t;
    int ki;
    l = blk[63:32];
    r = blk[31:0];
    for (int rnd = 0; rnd < 16; rnd++) begin
      ki = dec ? 15 - rnd : rnd;
      t  = r;
      r  = l ^ f_fn(r, keys[767-48*ki -: 48]);
      l  = t;
    end
    return {r, l};
  endfunction

  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c, d;
    logic [767:0] ks;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rnd = 0; rnd < 16; rnd++) begin
      for (int s = 0; s < SHIFT_T[rnd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[767-48*rnd-i] = cd[56-PC2_T[i]];
    end
    return ks;
  endfunction

  function automatic logic [767:0] rand768();
    logic [767:0] v;
    for (int i = 0; i < 24; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [63:0] data, input logic [767:0] keys, input logic dec, input logic [7:0] tag);
    in_data    = data;
    in_keys    = keys;
    in_decrypt = dec;
    in_tag     = tag;
    in_valid   = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) check($sformatf("in_ready_u%0d", 1 << i), 64'(in_ready_w[i]), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) check($sformatf("busy_u%0d", 1 << i), 64'(busy_w[i]), 64'd1);
  endtask

  task automatic collect(input logic [63:0] exp_data, input logic [7:0] exp_tag, input bit scramble);
    bit seen [5];
    for (int i = 0; i < 5; i++) seen[i] = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (scramble) begin
        in_keys    = rand768();
        in_decrypt = 1'($urandom);
        in_data    = {$urandom, $urandom};
      end
      tick();
      for (int i = 0; i < 5; i++) begin
        if (out_valid_w[i] && !seen[i]) begin
          seen[i]     = 1'b1;
          last_out[i] = out_data_w[i];
          check($sformatf("latency_u%0d", 1 << i), 64'(c), 64'(16 >> i));
          check($sformatf("data_u%0d", 1 << i), out_data_w[i], exp_data);
          check($sformatf("tag_u%0d", 1 << i), 64'(out_tag_w[i]), 64'(exp_tag));
        end
      end
    end
    for (int i = 0; i < 5; i++) check($sformatf("result_seen_u%0d", 1 << i), 64'(seen[i]), 64'd1);
    tick();
    $display("blk %0d tag=%h exp=%h u1=%h", blk_no, exp_tag, exp_data, last_out[0]);
    blk_no++;
  endtask

  task automatic idle_checks(input string tag);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_in_ready_u%0d", tag, 1 << i), 64'(in_ready_w[i]), 64'd1);
      check($sformatf("%s_out_valid_u%0d", tag, 1 << i), 64'(out_valid_w[i]), 64'd0);
      check($sformatf("%s_busy_u%0d", tag, 1 << i), 64'(busy_w[i]), 64'd0);
      check($sformatf("%s_out_data_u%0d", tag, 1 << i), out_data_w[i], 64'd0);
      check($sformatf("%s_out_tag_u%0d", tag, 1 << i), 64'(out_tag_w[i]), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [767:0] ks, kr;
    logic [63:0]  d, e;
    logic         m;
    logic [7:0]   t;
    int           stray;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_keys = '0; in_decrypt = 1'b0; in_tag = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    idle_checks("reset");

    // Known-answer encrypt and decrypt.
    ks = key_sched(64'h133457799BBCDFF1);
    d  = do_ip(64'h0123456789ABCDEF);
    launch(d, ks, 1'b0, 8'h3C);
    collect(model(d, ks, 1'b0), 8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) check($sformatf("kat_enc_u%0d", 1 << i), do_fp(last_out[i]), 64'h85E813540F0AB405);
    d = do_ip(64'h85E813540F0AB405);
    launch(d, ks, 1'b1, 8'hA5);
    collect(model(d, ks, 1'b1), 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) check($sformatf("kat_dec_u%0d", 1 << i), do_fp(last_out[i]), 64'h0123456789ABCDEF);

    // Random sweep.
    for (int n = 0; n < 1000; n++) begin
      kr = rand768();
      d  = {$urandom, $urandom};
      m  = 1'($urandom);
      t  = 8'($urandom);
      launch(d, kr, m, t);
      collect(model(d, kr, m), t, 1'b0);
    end

    // Keys, mode and data wiggled every cycle while in flight.
    for (int n = 0; n < 4; n++) begin
      kr = rand768();
      d  = {$urandom, $urandom};
      m  = 1'(n);
      t  = 8'(8'h50 + n);
      launch(d, kr, m, t);
      collect(model(d, kr, m), t, 1'b1);
    end

    // Backpressure: hold results for 10 cycles, then back-to-back accept.
    out_ready = 1'b0;
    kr = rand768();
    d  = {$urandom, $urandom};
    e  = model(d, kr, 1'b0);
    launch(d, kr, 1'b0, 8'h77);
    collect(e, 8'h77, 1'b0);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < 5; i++) begin
        check($sformatf("bp_valid_u%0d", 1 << i), 64'(out_valid_w[i]), 64'd1);
        check($sformatf("bp_data_u%0d", 1 << i), out_data_w[i], e);
        check($sformatf("bp_tag_u%0d", 1 << i), 64'(out_tag_w[i]), 64'h77);
        check($sformatf("bp_in_ready_u%0d", 1 << i), 64'(in_ready_w[i]), 64'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    kr = rand768();
    d  = {$urandom, $urandom};
    launch(d, kr, 1'b1, 8'h88);
    for (int i = 0; i < 5; i++) check($sformatf("b2b_valid_low_u%0d", 1 << i), 64'(out_valid_w[i]), 64'd0);
    collect(model(d, kr, 1'b1), 8'h88, 1'b0);

    // Reset in the middle of a block (rc=8 on the UNROLL=1 engine).
    kr = rand768();
    d  = {$urandom, $urandom};
    launch(d, kr, 1'b0, 8'h99);
    repeat (8) tick();
    check("mid_busy_u1", 64'(busy_w[0]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    idle_checks("midrst");
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int i = 0; i < 5; i++) if (out_valid_w[i]) stray++;
    end
    check("no_stale_result", 64'(stray), 64'd0);
    kr = rand768();
    d  = {$urandom, $urandom};
    launch(d, kr, 1'b0, 8'h11);
    collect(model(d, kr, 1'b0), 8'h11, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
